// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one valid/ready stream among N requesters.
// The output is a registered forward stage: one cycle of latency, one beat per cycle.
module stream_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic [N-1:0]    valid_i,
    input  logic [N-1:0]    last_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    ready_o,
    output logic            valid_o,
    output logic            last_o,
    output logic [DW-1:0]   data_o,
    output logic [IW-1:0]   idx_o,
    input  logic            ready_i
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          locked_q, locked_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          load;
    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic          xfer;

    assign load = !valid_q || ready_i;

    // A locked owner keeps the grant even while its valid is low, so others stay blocked.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (locked_q) begin
            gnt_any = 1'b1;
            gnt_idx = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!gnt_any && valid_i[(32'(ptr_q) + i) % N]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IW'((32'(ptr_q) + i) % N);
                end
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (rst_ni && !clear_i && load && gnt_any) begin
            ready_o[gnt_idx] = 1'b1;
        end
    end

    assign xfer = load && !clear_i && gnt_any && valid_i[gnt_idx];

    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        idx_d      = idx_q;
        if (clear_i) begin
            ptr_d      = '0;
            locked_d   = 1'b0;
            lock_idx_d = '0;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            data_d     = '0;
            idx_d      = '0;
        end else if (load) begin
            if (xfer) begin
                valid_d = 1'b1;
                last_d  = last_i[gnt_idx];
                data_d  = data_i[gnt_idx*DW +: DW];
                idx_d   = gnt_idx;
                if (last_i[gnt_idx]) begin
                    locked_d = 1'b0;
                    ptr_d    = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
                end else begin
                    locked_d   = 1'b1;
                    lock_idx_d = gnt_idx;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            idx_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (N=4, DW=8).
module tb_stream_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic [N-1:0]    valid_i;
    logic [N-1:0]    last_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    ready_o;
    logic            valid_o;
    logic            last_o;
    logic [DW-1:0]   data_o;
    logic [IW-1:0]   idx_o;
    logic            ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    stream_rr_arbiter #(.N(N), .DW(DW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .valid_i(valid_i),
        .last_i (last_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .last_o (last_o),
        .data_o (data_o),
        .idx_o  (idx_o),
        .ready_i(ready_i)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_data(input int k, input logic [DW-1:0] v);
        data_i[k*DW +: DW] = v;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; valid_i = 4'b0001; last_i = 4'b0001;
        data_i = '0; ready_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ready_in_reset: got %b want 0000", ready_o);
        end
        tick(); tick();
        n_cmp++;
        if (valid_o !== 1'b0 || idx_o !== 2'd0 || data_o !== 8'h00 || last_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b i=%0d d=%h l=%b want 0 0 00 0",
                     valid_o, idx_o, data_o, last_o);
        end
        valid_i = 4'b0000;
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 4'b0000) begin
            n_bad++; $display("FAIL idle_ready: got %b want 0000", ready_o);
        end
        valid_i = 4'b0001;
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL idle_req0_ready: got %b want 0001", ready_o);
        end
        valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) set_data(k, 8'hD0 + 8'(k));
        valid_i = 4'b1111; last_i = 4'b1111; ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (ready_o !== 4'(1 << (i % 4))) begin
                n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ready_o,
                                  4'(1 << (i % 4)));
            end
            tick();
            n_cmp++;
            if (valid_o !== 1'b1 || idx_o !== 2'(i % 4) || data_o !== 8'hD0 + 8'(i % 4)) begin
                n_bad++;
                $display("FAIL rr_beat[%0d]: got v=%b i=%0d d=%h want 1 %0d %h", i, valid_o,
                         idx_o, data_o, i % 4, 8'hD0 + 8'(i % 4));
            end
        end
        valid_i = 4'b0000;
        tick();
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_bad++; $display("FAIL rr_drain: got valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_packet_lock();
        // ptr is 0 here
        valid_i = 4'b0011; last_i = 4'b0010; set_data(0, 8'h10); set_data(1, 8'h21);
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL lock_b1_ready: got %b want 0001", ready_o);
        end
        tick();
        n_cmp++;
        if (valid_o !== 1'b1 || idx_o !== 2'd0 || data_o !== 8'h10 || last_o !== 1'b0) begin
            n_bad++; $display("FAIL lock_b1: got v=%b i=%0d d=%h l=%b want 1 0 10 0",
                              valid_o, idx_o, data_o, last_o);
        end
        set_data(0, 8'h11);
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL lock_b2_ready: got %b want 0001", ready_o);
        end
        tick();
        n_cmp++;
        if (idx_o !== 2'd0 || data_o !== 8'h11) begin
            n_bad++; $display("FAIL lock_b2: got i=%0d d=%h want 0 11", idx_o, data_o);
        end
        valid_i = 4'b0010;
        #1;
        n_cmp++;
        if (ready_o[1] !== 1'b0) begin
            n_bad++; $display("FAIL lock_bubble_ready1: got %b want 0", ready_o[1]);
        end
        tick();
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_bad++; $display("FAIL lock_bubble: got valid_o=%b want 0", valid_o);
        end
        valid_i = 4'b0011; last_i = 4'b0011; set_data(0, 8'h12);
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL lock_b3_ready: got %b want 0001", ready_o);
        end
        tick();
        n_cmp++;
        if (valid_o !== 1'b1 || idx_o !== 2'd0 || data_o !== 8'h12 || last_o !== 1'b1) begin
            n_bad++; $display("FAIL lock_b3: got v=%b i=%0d d=%h l=%b want 1 0 12 1",
                              valid_o, idx_o, data_o, last_o);
        end
        tick();
        n_cmp++;
        if (valid_o !== 1'b1 || idx_o !== 2'd1 || data_o !== 8'h21) begin
            n_bad++; $display("FAIL lock_rearb: got v=%b i=%0d d=%h want 1 1 21",
                              valid_o, idx_o, data_o);
        end
        valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        // ptr is 2 here
        valid_i = 4'b0100; last_i = 4'b1111; set_data(2, 8'hA5);
        tick();
        n_cmp++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5 || idx_o !== 2'd2) begin
            n_bad++; $display("FAIL bp_load: got v=%b d=%h i=%0d want 1 a5 2",
                              valid_o, data_o, idx_o);
        end
        ready_i = 1'b0; valid_i = 4'b0001; set_data(0, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ready_o !== 4'b0000) begin
                n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ready_o);
            end
            tick();
            n_cmp++;
            if (valid_o !== 1'b1 || data_o !== 8'hA5 || idx_o !== 2'd2) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h i=%0d want 1 a5 2", i,
                                  valid_o, data_o, idx_o);
            end
        end
        ready_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL bp_release_ready: got %b want 0001", ready_o);
        end
        tick();
        n_cmp++;
        if (valid_o !== 1'b1 || data_o !== 8'h5A || idx_o !== 2'd0) begin
            n_bad++; $display("FAIL bp_release: got v=%b d=%h i=%0d want 1 5a 0",
                              valid_o, data_o, idx_o);
        end
        valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        // ptr is 1; grant req2 to move ptr to 3
        valid_i = 4'b0100; last_i = 4'b1111; set_data(2, 8'hC2);
        tick();
        valid_i = 4'b1001; set_data(0, 8'hC0); set_data(3, 8'hC3);
        #1;
        n_cmp++;
        if (ready_o !== 4'b1000) begin
            n_bad++; $display("FAIL wrap_ready3: got %b want 1000", ready_o);
        end
        tick();
        n_cmp++;
        if (idx_o !== 2'd3 || data_o !== 8'hC3) begin
            n_bad++; $display("FAIL wrap_beat3: got i=%0d d=%h want 3 c3", idx_o, data_o);
        end
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL wrap_ready0: got %b want 0001", ready_o);
        end
        tick();
        n_cmp++;
        if (idx_o !== 2'd0 || data_o !== 8'hC0) begin
            n_bad++; $display("FAIL wrap_beat0: got i=%0d d=%h want 0 c0", idx_o, data_o);
        end
        valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_clear();
        // ptr is 1; lock onto req1 with a non-last beat
        valid_i = 4'b0010; last_i = 4'b0000; set_data(1, 8'hE1);
        tick();
        n_cmp++;
        if (valid_o !== 1'b1 || idx_o !== 2'd1 || data_o !== 8'hE1) begin
            n_bad++; $display("FAIL clr_lock_beat: got v=%b i=%0d d=%h want 1 1 e1",
                              valid_o, idx_o, data_o);
        end
        clear_i = 1'b1; valid_i = 4'b0011;
        #1;
        n_cmp++;
        if (ready_o !== 4'b0000) begin
            n_bad++; $display("FAIL clr_ready: got %b want 0000", ready_o);
        end
        tick();
        clear_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b0 || idx_o !== 2'd0 || data_o !== 8'h00 || last_o !== 1'b0) begin
            n_bad++; $display("FAIL clr_outputs: got v=%b i=%0d d=%h l=%b want 0 0 00 0",
                              valid_o, idx_o, data_o, last_o);
        end
        last_i = 4'b0011; set_data(0, 8'hE0);
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL clr_rearb_ready: got %b want 0001", ready_o);
        end
        tick();
        n_cmp++;
        if (idx_o !== 2'd0 || data_o !== 8'hE0) begin
            n_bad++; $display("FAIL clr_rearb: got i=%0d d=%h want 0 e0", idx_o, data_o);
        end
        valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        valid_i = 4'b0100; last_i = 4'b0000; set_data(2, 8'h77);
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            n_bad++; $display("FAIL async_reset: got v=%b d=%h want 0 00", valid_o, data_o);
        end
        valid_i = 4'b0001; last_i = 4'b0001;
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 4'b0001) begin
            n_bad++; $display("FAIL async_reset_unlock: got %b want 0001", ready_o);
        end
        valid_i = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_wrap();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
